// File: rtl/key_pkg.sv
// Shared definitions for the key handling blocks: FSM encoding and default timing constants.
package key_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } click_state_t;

  localparam int          CLK_FREQ_HZ      = 50_000_000;
  localparam logic [19:0] DEBOUNCE_CNT_MAX = 20'd999_999;
  localparam logic [23:0] CLICK_WIN_MAX    = 24'd12_499_999;
  localparam int          MAX_CLICKS_DEF   = 3;

endpackage

// File: rtl/key_win_timer.sv
// Clearable, enable-gated up-counter that parks at MAX and flags it.
// Intended to be reusable for long-press timing as well as the click window.
module key_win_timer #(
  parameter int         W   = 24,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == MAX);

endmodule

// File: rtl/key_click_decoder.sv
// Groups debounced press pulses into bursts and reports single/double/triple clicks.
//   state | meaning
//   IDLE  | no burst open, waiting for the first press
//   COUNT | burst open, counting presses while the window timer runs
module key_click_decoder
  import key_pkg::*;
#(
  parameter logic [23:0] WIN_MAX    = CLICK_WIN_MAX,
  parameter int          MAX_CLICKS = MAX_CLICKS_DEF,
  parameter int          CNT_W      = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             key_flag,
  output logic             click_valid,
  output logic [CNT_W-1:0] click_num,
  output logic             single_click,
  output logic             double_click,
  output logic             triple_click,
  output logic             busy
);

  localparam logic [CNT_W:0]   MAX_INC = (CNT_W + 1)'(MAX_CLICKS);
  localparam logic [CNT_W-1:0] MAX_NUM = CNT_W'(MAX_CLICKS);

  click_state_t     state;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_inc;
  logic             win_tc;
  logic             emit;
  logic [CNT_W-1:0] emit_num;

  assign count_inc = {1'b0, count} + 1'b1;

  // A press restarts the window, including on the terminal cycle itself.
  key_win_timer #(
    .W   (24),
    .MAX (WIN_MAX)
  ) u_win_timer (
    .clk (sys_clk),
    .rst (sys_rst),
    .clr ((state == IDLE) || key_flag || win_tc),
    .en  (state == COUNT),
    .tc  (win_tc)
  );

  always_comb begin
    emit     = 1'b0;
    emit_num = count;
    if (state == COUNT) begin
      if (key_flag && (count_inc == MAX_INC)) begin
        emit     = 1'b1;
        emit_num = MAX_NUM;
      end else if (!key_flag && win_tc) begin
        emit     = 1'b1;
        emit_num = count;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      count        <= '0;
      click_valid  <= 1'b0;
      click_num    <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      triple_click <= 1'b0;
    end else begin
      click_valid  <= emit;
      single_click <= emit && (emit_num == CNT_W'(1));
      double_click <= emit && (emit_num == CNT_W'(2));
      triple_click <= emit && (emit_num == CNT_W'(3));
      if (emit) begin
        click_num <= emit_num;
      end

      case (state)
        IDLE: begin
          if (key_flag) begin
            state <= COUNT;
            count <= CNT_W'(1);
          end
        end
        COUNT: begin
          if (emit) begin
            state <= IDLE;
            count <= '0;
          end else if (key_flag) begin
            count <= count_inc[CNT_W-1:0];
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign busy = (state == COUNT);

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed bench for key_click_decoder with WIN_MAX=9, MAX_CLICKS=3.
module tb_key_click_decoder;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_flag = 1'b0;
  logic       click_valid;
  logic [1:0] click_num;
  logic       single_click;
  logic       double_click;
  logic       triple_click;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  key_click_decoder #(
    .WIN_MAX    (24'd9),
    .MAX_CLICKS (3),
    .CNT_W      (2)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_flag     (key_flag),
    .click_valid  (click_valid),
    .click_num    (click_num),
    .single_click (single_click),
    .double_click (double_click),
    .triple_click (triple_click),
    .busy         (busy)
  );

  task automatic chk(input string tag, input int e, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s after edge %0d: observed %0d expected %0d", tag, e, obs, exp);
    end
  endtask

  // Runs edges 1..40 after a fresh reset (edge 0 = last reset edge).
  // press bit e => key_flag sampled at edge e; rst_e => sys_rst sampled at that edge.
  // Expected results: click_num vNn appears after edge vNe; busy after edges in [bNlo,bNhi].
  task automatic run(input string name, input logic [63:0] press, input int rst_e,
                     input int v1e, input int v1n, input int v2e, input int v2n,
                     input int b1lo, input int b1hi, input int b2lo, input int b2hi);
    int exp_n;
    int last_n;
    logic exp_b;
    sys_rst  = 1'b1;
    key_flag = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    chk({name, ":rst_valid"}, 0, {7'd0, click_valid}, 8'd0);
    chk({name, ":rst_num"},   0, {6'd0, click_num}, 8'd0);
    chk({name, ":rst_types"}, 0, {5'd0, single_click, double_click, triple_click}, 8'd0);
    chk({name, ":rst_busy"},  0, {7'd0, busy}, 8'd0);
    last_n = 0;
    for (int e = 1; e <= 40; e++) begin
      key_flag = press[e];
      sys_rst  = (e == rst_e);
      @(posedge sys_clk);
      #1;
      key_flag = 1'b0;
      sys_rst  = 1'b0;
      exp_n = (e == v1e) ? v1n : (e == v2e) ? v2n : 0;
      exp_b = ((e >= b1lo) && (e <= b1hi)) || ((e >= b2lo) && (e <= b2hi));
      if (e == rst_e) last_n = 0;
      if (exp_n != 0) last_n = exp_n;
      chk({name, ":valid"}, e, {7'd0, click_valid}, {7'd0, (exp_n != 0)});
      chk({name, ":num"},   e, {6'd0, click_num}, 8'(last_n));
      chk({name, ":types"}, e, {5'd0, single_click, double_click, triple_click},
          {5'd0, (exp_n == 1), (exp_n == 2), (exp_n == 3)});
      chk({name, ":busy"},  e, {7'd0, busy}, {7'd0, exp_b});
    end
  endtask

  initial begin
    // single press: result after edge 20
    run("single", 64'd1 << 10, -1, 20, 1, -1, 0, 10, 19, -1, -2);
    // double press: result after edge 25, nothing after 20
    run("double", (64'd1 << 10) | (64'd1 << 15), -1, 25, 2, -1, 0, 10, 24, -1, -2);
    // triple ends early at edge 18; press at 20 opens a new single burst
    run("triple", (64'd1 << 10) | (64'd1 << 14) | (64'd1 << 18) | (64'd1 << 20), -1,
        18, 3, 30, 1, 10, 17, 20, 29);
    // press on the terminal window cycle still counts
    run("win_edge", (64'd1 << 10) | (64'd1 << 20), -1, 30, 2, -1, 0, 10, 29, -1, -2);
    // one cycle later it is a separate burst
    run("win_past", (64'd1 << 10) | (64'd1 << 21), -1, 20, 1, 31, 1, 10, 19, 21, 30);
    // reset mid-burst discards it
    run("rst_mid", (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 20), 14,
        30, 1, -1, 0, 10, 13, 20, 29);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
